// File: rtl/exec_mem_responder_if.sv
// Bundle of the EXEC data-memory request/response signals plus preload and status.
// The master side is the EXEC unit or a bench; the slave side is exec_mem_responder.
interface exec_mem_responder_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12
) ();
  logic                  exec_rd_req;
  logic [ADDR_WIDTH-1:0] exec_rd_addr;
  logic [DATA_WIDTH-1:0] exec_rd_data;
  logic                  exec_rd_valid;
  logic                  exec_wr_req;
  logic [ADDR_WIDTH-1:0] exec_wr_addr;
  logic [DATA_WIDTH-1:0] exec_wr_data;
  logic                  ld_en;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  mem_ready;
  logic                  req_err;
  logic [15:0]           rd_cnt;
  logic [15:0]           wr_cnt;

  modport master (
    output exec_rd_req, exec_rd_addr, exec_wr_req, exec_wr_addr, exec_wr_data,
           ld_en, ld_addr, ld_data,
    input  exec_rd_data, exec_rd_valid, mem_ready, req_err, rd_cnt, wr_cnt
  );

  modport slave (
    input  exec_rd_req, exec_rd_addr, exec_wr_req, exec_wr_addr, exec_wr_data,
           ld_en, ld_addr, ld_data,
    output exec_rd_data, exec_rd_valid, mem_ready, req_err, rd_cnt, wr_cnt
  );
endinterface

// File: rtl/exec_mem_responder.sv
// Data-memory responder for the EXEC unit: clears the array after reset, then serves
// write-first reads with a fixed pipelined latency, same-cycle writes and preloads.
module exec_mem_responder #(
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    DATA_WIDTH = 12,
  parameter int                    DEPTH      = 4096,
  parameter int                    RD_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  exec_mem_responder_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      clr_ptr_q, clr_ptr_d;
  logic                  req_err_q, req_err_d;
  logic [15:0]           rd_cnt_q, rd_cnt_d;
  logic [15:0]           wr_cnt_q, wr_cnt_d;

  logic                  mem_we;
  logic [IDX_W-1:0]      mem_waddr;
  logic [IDX_W-1:0]      mem_raddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  rd_fire;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_ram_q;

  // Same-edge write hit is remembered beside the RAM output so the array keeps a plain registered read.
  logic                  byp_q, byp_d;
  logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;
  logic                  ram_vld_q, ram_vld_d;
  logic [DATA_WIDTH-1:0] ram_word;

  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [DATA_WIDTH-1:0] pipe_q [RD_LATENCY];
  logic [DATA_WIDTH-1:0] pipe_d [RD_LATENCY];

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    req_err_d  = req_err_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    mem_we     = 1'b0;
    mem_waddr  = clr_ptr_q;
    mem_wdata  = INIT_VALUE;
    mem_raddr  = bus.exec_rd_addr[IDX_W-1:0];
    rd_fire    = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == IDX_W'(DEPTH - 1)) begin
          state_d = ST_READY;
        end
        if (bus.exec_rd_req || bus.exec_wr_req || bus.ld_en) begin
          req_err_d = 1'b1;
        end
      end
      ST_READY: begin
        if (bus.exec_wr_req) begin
          mem_we    = 1'b1;
          mem_waddr = bus.exec_wr_addr[IDX_W-1:0];
          mem_wdata = bus.exec_wr_data;
          if (wr_cnt_q != 16'hFFFF) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
          end
          if (bus.ld_en) begin
            req_err_d = 1'b1;
          end
        end else if (bus.ld_en) begin
          mem_we    = 1'b1;
          mem_waddr = bus.ld_addr[IDX_W-1:0];
          mem_wdata = bus.ld_data;
        end
        if (bus.exec_rd_req) begin
          rd_fire = 1'b1;
          if (rd_cnt_q != 16'hFFFF) begin
            rd_cnt_d = rd_cnt_q + 16'd1;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase

    byp_d      = rd_fire && mem_we && (mem_waddr == mem_raddr);
    byp_data_d = mem_wdata;
    ram_vld_d  = rd_fire;
    ram_word   = byp_q ? byp_data_q : rd_ram_q;
  end

  // Each stage only takes a new word when one arrives, so the last stage holds the previous result.
  genvar gi;
  generate
    for (gi = 0; gi < RD_LATENCY; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign vld_d[gi]  = ram_vld_q;
        assign pipe_d[gi] = ram_vld_q ? ram_word : pipe_q[gi];
      end else begin : g_next
        assign vld_d[gi]  = vld_q[gi-1];
        assign pipe_d[gi] = vld_q[gi-1] ? pipe_q[gi-1] : pipe_q[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_CLEAR;
      clr_ptr_q  <= '0;
      req_err_q  <= 1'b0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
      ram_vld_q  <= 1'b0;
      vld_q      <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      req_err_q  <= req_err_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      byp_q      <= byp_d;
      byp_data_q <= byp_data_d;
      ram_vld_q  <= ram_vld_d;
      vld_q      <= vld_d;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && reset_n) begin
      mem[mem_waddr] <= mem_wdata;
    end
    rd_ram_q <= mem[mem_raddr];
  end

  generate
    if (IDX_W < ADDR_WIDTH) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^{bus.exec_rd_addr[ADDR_WIDTH-1:IDX_W],
                                bus.exec_wr_addr[ADDR_WIDTH-1:IDX_W],
                                bus.ld_addr[ADDR_WIDTH-1:IDX_W]};
    end
  endgenerate

  assign bus.exec_rd_data  = pipe_q[RD_LATENCY-1];
  assign bus.exec_rd_valid = vld_q[RD_LATENCY-1];
  assign bus.mem_ready     = (state_q == ST_READY);
  assign bus.req_err       = req_err_q;
  assign bus.rd_cnt        = rd_cnt_q;
  assign bus.wr_cnt        = wr_cnt_q;
endmodule

// File: tb/tb_exec_mem_responder.sv
// Directed bench for exec_mem_responder: a latency-1 and a latency-3 instance, both DEPTH=16,
// sharing clock and reset; a vector table plus hand sequences for clear, latency and reset.
module tb_exec_mem_responder;
  localparam int          AW    = 12;
  localparam int          DW    = 12;
  localparam int          DEPTH = 16;
  localparam logic [11:0] INIT  = 12'h5A5;

  logic clk = 1'b0;
  logic reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  exec_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
  exec_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus3 ();

  exec_mem_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RD_LATENCY(1), .INIT_VALUE(INIT)
  ) dut (.clk(clk), .reset_n(reset_n), .bus(bus1));

  exec_mem_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RD_LATENCY(3), .INIT_VALUE(INIT)
  ) dut3 (.clk(clk), .reset_n(reset_n), .bus(bus3));

  typedef struct packed {
    logic        rd;  logic [11:0] ra;
    logic        wr;  logic [11:0] wa;  logic [11:0] wd;
    logic        ld;  logic [11:0] la;  logic [11:0] ldat;
    logic        ev;  logic [11:0] ed;  logic        ee;
    logic [15:0] erc; logic [15:0] ewc;
  } vec_t;

  vec_t vt [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %h", name, act);
    end
  endtask

  task automatic idle1();
    bus1.exec_rd_req = 1'b0; bus1.exec_rd_addr = '0;
    bus1.exec_wr_req = 1'b0; bus1.exec_wr_addr = '0; bus1.exec_wr_data = '0;
    bus1.ld_en = 1'b0; bus1.ld_addr = '0; bus1.ld_data = '0;
  endtask

  task automatic idle3();
    bus3.exec_rd_req = 1'b0; bus3.exec_rd_addr = '0;
    bus3.exec_wr_req = 1'b0; bus3.exec_wr_addr = '0; bus3.exec_wr_data = '0;
    bus3.ld_en = 1'b0; bus3.ld_addr = '0; bus3.ld_data = '0;
  endtask

  initial begin
    //        rd   ra        wr   wa        wd        ld   la      ldat     ev   ed      ee   erc    ewc
    vt[0]  = '{1'b0, 12'h000,  1'b1, 12'o0200, 12'o7777, 1'b0, 12'h000, 12'h000, 1'b0, 12'h000, 1'b0, 16'd0, 16'd1};
    vt[1]  = '{1'b1, 12'o0200, 1'b0, 12'h000,  12'h000,  1'b0, 12'h000, 12'h000, 1'b0, 12'h000, 1'b0, 16'd1, 16'd1};
    vt[2]  = '{1'b0, 12'h000,  1'b0, 12'h000,  12'h000,  1'b0, 12'h000, 12'h000, 1'b1, 12'hFFF, 1'b0, 16'd1, 16'd1};
    vt[3]  = '{1'b0, 12'h000,  1'b0, 12'h000,  12'h000,  1'b0, 12'h000, 12'h000, 1'b0, 12'hFFF, 1'b0, 16'd1, 16'd1};
    vt[4]  = '{1'b1, 12'h010,  1'b1, 12'h010,  12'h0A5,  1'b0, 12'h000, 12'h000, 1'b0, 12'hFFF, 1'b0, 16'd2, 16'd2};
    vt[5]  = '{1'b0, 12'h000,  1'b0, 12'h000,  12'h000,  1'b0, 12'h000, 12'h000, 1'b1, 12'h0A5, 1'b0, 16'd2, 16'd2};
    vt[6]  = '{1'b1, 12'h003,  1'b0, 12'h000,  12'h000,  1'b0, 12'h000, 12'h000, 1'b0, 12'h0A5, 1'b0, 16'd3, 16'd2};
    vt[7]  = '{1'b0, 12'h000,  1'b0, 12'h000,  12'h000,  1'b1, 12'h017, 12'h123, 1'b1, 12'h5A5, 1'b0, 16'd3, 16'd2};
    vt[8]  = '{1'b1, 12'h007,  1'b0, 12'h000,  12'h000,  1'b0, 12'h000, 12'h000, 1'b0, 12'h5A5, 1'b0, 16'd4, 16'd2};
    vt[9]  = '{1'b1, 12'hFF7,  1'b0, 12'h000,  12'h000,  1'b0, 12'h000, 12'h000, 1'b1, 12'h123, 1'b0, 16'd5, 16'd2};
    vt[10] = '{1'b0, 12'h000,  1'b0, 12'h000,  12'h000,  1'b0, 12'h000, 12'h000, 1'b1, 12'h123, 1'b0, 16'd5, 16'd2};
    vt[11] = '{1'b0, 12'h000,  1'b1, 12'h005,  12'h0BB,  1'b1, 12'h005, 12'h0CC, 1'b0, 12'h123, 1'b1, 16'd5, 16'd3};
    vt[12] = '{1'b1, 12'h005,  1'b0, 12'h000,  12'h000,  1'b0, 12'h000, 12'h000, 1'b0, 12'h123, 1'b1, 16'd6, 16'd3};
    vt[13] = '{1'b0, 12'h000,  1'b1, 12'h005,  12'h0DD,  1'b0, 12'h000, 12'h000, 1'b1, 12'h0BB, 1'b1, 16'd6, 16'd4};
    vt[14] = '{1'b1, 12'h005,  1'b0, 12'h000,  12'h000,  1'b0, 12'h000, 12'h000, 1'b0, 12'h0BB, 1'b1, 16'd7, 16'd4};
    vt[15] = '{1'b0, 12'h000,  1'b0, 12'h000,  12'h000,  1'b0, 12'h000, 12'h000, 1'b1, 12'h0DD, 1'b1, 16'd7, 16'd4};

    idle1();
    idle3();
    reset_n = 1'b0;
    tick();
    tick();
    check("reset rd_data",   16'(bus1.exec_rd_data), 16'h000);
    check("reset rd_valid",  16'(bus1.exec_rd_valid), 16'h0);
    check("reset mem_ready", 16'(bus1.mem_ready), 16'h0);
    check("reset req_err",   16'(bus1.req_err), 16'h0);
    check("reset rd_cnt",    bus1.rd_cnt, 16'd0);
    check("reset wr_cnt",    bus1.wr_cnt, 16'd0);

    // Clear takes exactly DEPTH edges after release.
    reset_n = 1'b1;
    for (int k = 1; k <= DEPTH; k++) begin
      tick();
      check($sformatf("clear%0d mem_ready", k), 16'(bus1.mem_ready), (k == DEPTH) ? 16'h1 : 16'h0);
    end
    check("clear req_err", 16'(bus1.req_err), 16'h0);
    check("clear l3 mem_ready", 16'(bus3.mem_ready), 16'h1);

    for (int i = 0; i < 16; i++) begin
      bus1.exec_rd_req  = vt[i].rd;  bus1.exec_rd_addr = vt[i].ra;
      bus1.exec_wr_req  = vt[i].wr;  bus1.exec_wr_addr = vt[i].wa; bus1.exec_wr_data = vt[i].wd;
      bus1.ld_en        = vt[i].ld;  bus1.ld_addr      = vt[i].la; bus1.ld_data      = vt[i].ldat;
      tick();
      check($sformatf("vec%0d rd_valid", i), 16'(bus1.exec_rd_valid), 16'(vt[i].ev));
      check($sformatf("vec%0d rd_data", i),  16'(bus1.exec_rd_data),  16'(vt[i].ed));
      check($sformatf("vec%0d req_err", i),  16'(bus1.req_err),       16'(vt[i].ee));
      check($sformatf("vec%0d rd_cnt", i),   bus1.rd_cnt,             vt[i].erc);
      check($sformatf("vec%0d wr_cnt", i),   bus1.wr_cnt,             vt[i].ewc);
    end
    idle1();

    // Latency 3: preload, then three back-to-back reads return in order at T+3..T+5.
    for (int k = 1; k <= 3; k++) begin
      bus3.ld_en   = 1'b1;
      bus3.ld_addr = 12'(k);
      bus3.ld_data = 12'(k * 12'h111);
      tick();
    end
    idle3();
    for (int k = 0; k <= 6; k++) begin
      bus3.exec_rd_req  = (k < 3);
      bus3.exec_rd_addr = 12'(k + 1);
      tick();
      check($sformatf("l3 t%0d rd_valid", k), 16'(bus3.exec_rd_valid), (k >= 3 && k <= 5) ? 16'h1 : 16'h0);
      check($sformatf("l3 t%0d rd_data", k), 16'(bus3.exec_rd_data),
            (k < 3) ? 16'h000 : (k == 3) ? 16'h111 : (k == 4) ? 16'h222 : 16'h333);
    end
    idle3();
    check("l3 rd_cnt", bus3.rd_cnt, 16'd3);
    check("l3 wr_cnt", bus3.wr_cnt, 16'd0);

    // Reset one cycle with a read in flight: no valid pulse and everything cleared.
    bus1.exec_rd_req  = 1'b1;
    bus1.exec_rd_addr = 12'h005;
    tick();
    idle1();
    reset_n = 1'b0;
    tick();
    check("rst6 rd_valid",  16'(bus1.exec_rd_valid), 16'h0);
    check("rst6 rd_data",   16'(bus1.exec_rd_data), 16'h000);
    check("rst6 mem_ready", 16'(bus1.mem_ready), 16'h0);
    check("rst6 req_err",   16'(bus1.req_err), 16'h0);
    check("rst6 rd_cnt",    bus1.rd_cnt, 16'd0);
    check("rst6 wr_cnt",    bus1.wr_cnt, 16'd0);
    reset_n = 1'b1;

    // Requests during the re-clear, aimed at words already cleared, must be ignored.
    for (int k = 1; k <= DEPTH; k++) begin
      if (k == 10) begin
        bus1.exec_rd_req = 1'b1; bus1.exec_rd_addr = 12'h002;
        bus1.exec_wr_req = 1'b1; bus1.exec_wr_addr = 12'h003; bus1.exec_wr_data = 12'h777;
        bus1.ld_en       = 1'b1; bus1.ld_addr      = 12'h004; bus1.ld_data      = 12'h666;
      end else begin
        idle1();
      end
      tick();
      if (k == 10) check("clr req_err", 16'(bus1.req_err), 16'h1);
      if (k == 11) check("clr rd_valid", 16'(bus1.exec_rd_valid), 16'h0);
      if (k >= 15) check($sformatf("reclear%0d mem_ready", k), 16'(bus1.mem_ready), (k == DEPTH) ? 16'h1 : 16'h0);
    end
    check("clr req_err sticky", 16'(bus1.req_err), 16'h1);
    check("clr rd_cnt", bus1.rd_cnt, 16'd0);
    check("clr wr_cnt", bus1.wr_cnt, 16'd0);

    // Every word reads back INIT after the re-clear.
    for (int k = 0; k <= DEPTH; k++) begin
      bus1.exec_rd_req  = (k < DEPTH);
      bus1.exec_rd_addr = 12'(k);
      tick();
      if (k > 0) begin
        check($sformatf("init a%0d rd_valid", k - 1), 16'(bus1.exec_rd_valid), 16'h1);
        check($sformatf("init a%0d rd_data", k - 1), 16'(bus1.exec_rd_data), 16'(INIT));
      end
    end
    idle1();
    tick();
    check("init done rd_valid", 16'(bus1.exec_rd_valid), 16'h0);
    check("init rd_cnt", bus1.rd_cnt, 16'd16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
